// File: rtl/pipe_pkg.sv
// Shared types and default widths for the elastic pipeline stage registers.
// The occupancy enum is shared by every stage buffer instance.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  // EX/MEM sized defaults; other stages override at instantiation.
  localparam int PIPE_DATA_W = 96;
  localparam int PIPE_CTRL_W = 8;
  localparam int PIPE_CNT_W  = 32;

endpackage

// File: rtl/pipe_sat_ctr.sv
// Saturating up-counter with enable; holds at all-ones once reached.
// Only the reset clears it.
module pipe_sat_ctr #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE = W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  cnt <= '0;
    else if (en && cnt != '1)  cnt <= cnt + ONE;
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline register: valid/ready stage with a 2-entry skid buffer.
// Optional stall counter enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  pipe_state_e       state_q, state_d;
  logic              in_ready_q;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              accept, consume;
  logic              load_main_in, load_main_skid, load_skid;

  assign accept  = in_valid && in_ready_q;
  assign consume = out_valid && out_ready;

  // State register; in_ready is a registered view of the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  // Next state and entry load strobes; flush overrides every transition.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            load_main_in = 1'b1;
            state_d      = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (accept && consume) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_d   = ST_FULL;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (consume) begin
            load_main_skid = 1'b1;
            state_d        = ST_BUSY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Entry storage; contents are left untouched on flush so out_data holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      if (load_main_in) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

  // Bubbles carry zero control bits regardless of stale main contents.
  always_comb begin
    in_ready  = in_ready_q;
    out_valid = (state_q != ST_EMPTY);
    out_ctrl  = out_valid ? main_ctrl : '0;
    out_data  = main_data;
  end

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_ctr #(.W(CNT_W)) u_stall_ctr (
    .clk (clk),
    .rst (rst),
    .en  (out_valid && !out_ready),
    .cnt (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: driver queues expected beats, monitor pops on handshake.
// Stall-counter checks are compiled in when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_buf;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int NW = 3;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [NW-1:0] stall_cnt;
`endif

  beat_t exp_q[$];
  beat_t mon_e;
  int    checks = 0;
  int    errors = 0;

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every downstream handshake must match the head of the queue.
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data %0h ctrl %0h expected none", out_data, out_ctrl);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat_data", 64'(out_data), 64'(mon_e.d));
        check("beat_ctrl", 64'(out_ctrl), 64'(mon_e.c));
      end
    end
  end

  // Present a beat until accepted; returns at posedge+1 with in_valid low.
  task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] c, input bit expect_out);
    bit    ok = 1'b0;
    beat_t b;
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
    if (expect_out) begin
      b.c = c;
      b.d = d;
      exp_q.push_back(b);
    end
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready 0 for data %0h expected acceptance", d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;

    // Reset and idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_ctrl",  64'(out_ctrl),  64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
`ifdef PIPE_STAGE_PERF_EN
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    check("in_ready_before_edge", 64'(in_ready), 64'd0);
    tick(1);
    check("in_ready_after_edge", 64'(in_ready), 64'd1);

    // Streaming back-to-back
    out_ready = 1'b1;
    send(32'hDEADBEEF, 4'hA, 1'b1);
    check("stream_lat_valid", 64'(out_valid), 64'd1);
    check("stream_lat_data",  64'(out_data),  64'hDEADBEEF);
    send(32'h87654321, 4'h5, 1'b1);
    check("stream_b_data", 64'(out_data), 64'h87654321);
    check("stream_b_ctrl", 64'(out_ctrl), 64'h5);
    tick(1);
    check("stream_idle_valid", 64'(out_valid), 64'd0);
    check("stream_idle_ctrl",  64'(out_ctrl),  64'd0);

    // Back-pressure: third beat must be blocked until release
    out_ready = 1'b0;
    send(32'h1, 4'h1, 1'b1);
    send(32'h2, 4'h2, 1'b1);
    in_valid = 1'b1; in_data = 32'h3; in_ctrl = 4'h3;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    check("bp_hold_data", 64'(out_data), 64'h1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h3, 4'h3, 1'b1);
    tick(4);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Flush while FULL; 0x200 and the held entries must never emerge
    out_ready = 1'b0;
    send(32'h10, 4'h1, 1'b0);
    send(32'h11, 4'h2, 1'b0);
    tick(10);
`ifdef PIPE_STAGE_PERF_EN
    check("stall_sat", 64'(stall_cnt), 64'd7);
`endif
    in_valid = 1'b1; in_data = 32'h200; in_ctrl = 4'hF; flush = 1'b1;
    tick(1);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_out_ctrl",  64'(out_ctrl),  64'd0);
    check("flush_in_ready",  64'(in_ready),  64'd1);
    check("flush_data_held", 64'(out_data),  64'h10);
`ifdef PIPE_STAGE_PERF_EN
    check("stall_after_flush", 64'(stall_cnt), 64'd7);
`endif
    out_ready = 1'b1;
    tick(4);

    // Asynchronous reset while BUSY
    out_ready = 1'b0;
    send(32'h30, 4'h6, 1'b0);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check("async_rst_valid",    64'(out_valid), 64'd0);
    check("async_rst_ctrl",     64'(out_ctrl),  64'd0);
    check("async_rst_in_ready", 64'(in_ready),  64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    tick(3);
`ifdef PIPE_STAGE_PERF_EN
    check("stall_cleared", 64'(stall_cnt), 64'd0);
`endif
    send(32'h40, 4'h7, 1'b1);
    tick(3);
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised elastic pipeline register for the 5-stage RISC-V core. It carries one stage's payload: the data word plus the control bits, such as mem_read, mem_write, reg_write, branch and jump. It uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure from a stalled downstream stage never drops or duplicates an instruction. Synchronous flush inserts a bubble with all control bits zeroed. It replaces the fixed-field IF/ID, ID/EX, EX/MEM and MEM/WB registers.

## Interface
- DATA_W, 96: payload data width (results, targets, operands, rd, opcode, func3 packed by caller)
- CTRL_W, 8: control-bit width; these bits are forced to 0 for bubbles
- CNT_W, 32: stall counter width (only with PIPE_STAGE_PERF_EN)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- flush  input  1  synchronous squash of all held entries
- in_valid  input  1  upstream beat present
- in_ready  output  1  registered; stage can accept a beat
- in_ctrl  input  CTRL_W  upstream control bits
- in_data  input  DATA_W  upstream payload
- out_valid  output  1  downstream beat present
- out_ready  input  1  downstream accepts
- out_ctrl  output  CTRL_W  control bits; 0 whenever out_valid=0
- out_data  output  DATA_W  payload; holds last value when out_valid=0
- stall_cnt  output  CNT_W  saturating count of back-pressure cycles (PIPE_STAGE_PERF_EN only)

## Operation
- Storage: main entry (drives outputs) and skid entry. States: EMPTY, BUSY (main only), FULL (main + skid).
- An input beat is accepted when in_valid && in_ready. An output beat is consumed when out_valid && out_ready.
- EMPTY: accept -> load main, BUSY.
- BUSY, accept && consume -> main <= input, BUSY.
- BUSY, accept && !consume -> skid <= input, FULL.
- BUSY, !accept && consume -> EMPTY.
- BUSY, otherwise -> hold.
- FULL: in_ready=0; consume -> main <= skid, BUSY; otherwise hold.
- in_ready = (next state != FULL), registered.
- out_valid = (state != EMPTY).
- Flush has highest priority over every transition. On flush, next state is EMPTY and both entries are invalidated. A beat accepted in the flush cycle is discarded. out_data is not cleared.
- Order is strictly FIFO; no beat is lost or duplicated.

## Timing
- Reset (rst=0, asynchronous): state EMPTY, out_valid 0, out_ctrl 0, out_data 0, in_ready 0, stall_cnt 0.
- in_ready rises at the first rising edge after rst deasserts.
- Latency in EMPTY: a beat accepted at edge N is on out_* immediately after edge N.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- Back-pressure: after out_ready drops, at most one further beat is absorbed (into skid). in_ready is low from the next edge.
- On release of out_ready in FULL: main is consumed that edge and skid advances. in_ready returns high one edge later.
- Flush with out_ready=1 in the same cycle: the downstream handshake of the current beat still completes, because outputs are registered. The state afterwards is EMPTY.
- Reset mid-transfer discards all entries immediately.

## Configuration
- PIPE_STAGE_PERF_EN defined: stall_cnt port exists. It increments each edge where out_valid && !out_ready and saturates at all-ones.
  - Cleared only by rst; flush does not clear it.
- PIPE_STAGE_PERF_EN undefined: stall_cnt port and counter logic are absent. Handshake behaviour is identical.

## Structure
- pipe_pkg holds:
  - the typedef enum for EMPTY/BUSY/FULL (2 bits);
  - default width constants used by core stage instances (EX/MEM data 96, ctrl 8).
- One sub-module: pipe_sat_ctr (parametrised CNT_W saturating counter with enable). It is instantiated only under PIPE_STAGE_PERF_EN.

## Test plan
- Reset/idle: hold rst=0 for 2 cycles, then release.
  - During reset: out_valid=0, out_ctrl=0, in_ready=0.
  - in_ready=1 after the first edge.
- Streaming: DATA_W=32, CTRL_W=4, out_ready=1, send data 0xDEADBEEF/ctrl 0xA then 0x87654321/ctrl 0x5 back-to-back.
  - Each appears one cycle after acceptance, in order, with no gaps.
- Back-pressure: out_ready=0 while sending 3 beats (0x1, 0x2, 0x3).
  - 0x1 and 0x2 are accepted; in_ready=0 blocks 0x3.
  - Raise out_ready: output is 0x1, 0x2, 0x3 with no loss or duplicate.
- Flush in FULL: flush=1 with in_valid=1 and data 0x200.
  - Next cycle out_valid=0, out_ctrl=0, in_ready=1; 0x200 never appears.
- Async reset mid-stream: drop rst between edges while in BUSY.
  - out_valid falls without waiting for an edge; no stale beat appears after release.
- PIPE_STAGE_PERF_EN with CNT_W=3: hold the stage FULL with out_ready=0 for 10 cycles.
  - stall_cnt saturates at 7.
  - A flush leaves it at 7.
